// File: rtl/recur_sched_ctrl_if.sv
// Start/status, ROM-read and execute-unit handshake signals of recur_sched_ctrl.
// The slave modport is the controller side; the master modport is its environment.
interface recur_sched_ctrl_if #(
    parameter int IW = 8,
    parameter int DW = 32
);
    localparam int FW = 4 * IW;

    logic              start;
    logic [FW-1:0]     root_frame;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              rom_ce;
    logic              rom_sel;
    logic [IW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              ex_valid;
    logic [FW-1:0]     ex_frame;
    logic [DW-1:0]     ex_d;
    logic [DW-1:0]     ex_occ_k;
    logic [DW-1:0]     ex_occ_l;
    logic              ex_ready;
    logic [2:0]        ex_push_cnt;
    logic [4*FW-1:0]   ex_push_frames;

    modport master (
        output start, root_frame, rom_data, ex_ready, ex_push_cnt, ex_push_frames,
        input  busy, done, overflow, rom_ce, rom_sel, rom_addr,
               ex_valid, ex_frame, ex_d, ex_occ_k, ex_occ_l
    );

    modport slave (
        input  start, root_frame, rom_data, ex_ready, ex_push_cnt, ex_push_frames,
        output busy, done, overflow, rom_ce, rom_sel, rom_addr,
               ex_valid, ex_frame, ex_d, ex_occ_k, ex_occ_l
    );
endinterface

// File: rtl/recur_sched_ctrl.sv
// Stack-driven traversal controller: pops a frame, fetches D(i), Occ(k-1) and Occ(l) from ROM,
// offers it to the execute unit and pushes back up to four child frames it returns.
module recur_sched_ctrl #(
    parameter int IW      = 8,
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    recur_sched_ctrl_if.slave bus
);
    localparam int FW  = 4 * IW;
    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;
    localparam int CW  = $clog2(ROM_LAT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        RD_D  = 3'd2,
        RD_OK = 3'd3,
        RD_OL = 3'd4,
        EXEC  = 3'd5,
        PUSH  = 3'd6,
        DONE  = 3'd7
    } state_t;

    function automatic logic [IW-1:0] frame_i(input logic [FW-1:0] f);
        return f[4*IW-1 -: IW];
    endfunction

    function automatic logic [IW-1:0] frame_k(input logic [FW-1:0] f);
        return f[2*IW-1 -: IW];
    endfunction

    function automatic logic [IW-1:0] frame_l(input logic [FW-1:0] f);
        return f[IW-1:0];
    endfunction

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic [SPW-1:0]  sp_r;
    logic [FW-1:0]   stack_r [DEPTH];
    logic [FW-1:0]   cur_frame_r;
    logic [FW-1:0]   next_frame_s;
    logic [FW-1:0]   push_frame_s;
    logic [4*FW-1:0] push_frames_r;
    logic [1:0]      push_idx_r;
    logic [2:0]      push_cnt_sat_s;
    logic [AW-1:0]   top_idx_s;
    logic            rd_last_s, rd_enter_s, accept_s, stack_full_s, k_zero_s;
    logic            rom_sel_s;
    logic [IW-1:0]   rom_addr_s;

    logic            busy_r, done_r, overflow_r, rom_ce_r, rom_sel_r, ex_valid_r;
    logic [IW-1:0]   rom_addr_r;
    logic [DW-1:0]   ex_d_r, ex_occ_k_r, ex_occ_l_r;

    assign rd_last_s      = (cnt_r == CW'(ROM_LAT));
    assign accept_s       = (state_r == EXEC) && bus.ex_ready;
    assign stack_full_s   = (sp_r == SPW'(DEPTH));
    assign top_idx_s      = AW'(sp_r - SPW'(1));
    assign k_zero_s       = (frame_k(cur_frame_r) == IW'(0));
    assign push_cnt_sat_s = (bus.ex_push_cnt > 3'd4) ? 3'd4 : bus.ex_push_cnt;
    assign push_frame_s   = push_frames_r[push_idx_r * FW +: FW];
    // The frame being popped is not in cur_frame_r yet, so the D address comes straight from the stack.
    assign next_frame_s   = (state_r == POP) ? stack_r[top_idx_s] : cur_frame_r;

    // Next-state logic of the traversal FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) state_s = POP;
                else           state_s = IDLE;
            end
            POP: state_s = RD_D;
            RD_D: begin
                if (!rd_last_s)    state_s = RD_D;
                else if (k_zero_s) state_s = RD_OL;
                else               state_s = RD_OK;
            end
            RD_OK: begin
                if (rd_last_s) state_s = RD_OL;
                else           state_s = RD_OK;
            end
            RD_OL: begin
                if (rd_last_s) state_s = EXEC;
                else           state_s = RD_OL;
            end
            EXEC: begin
                if (!accept_s)                      state_s = EXEC;
                else if (push_cnt_sat_s != 3'd0)    state_s = PUSH;
                else if (sp_r == SPW'(0))           state_s = DONE;
                else                                state_s = POP;
            end
            PUSH: begin
                // Every push either stores a frame or finds the stack full, so it is never empty here.
                if (push_idx_r == 2'd0) state_s = POP;
                else                    state_s = PUSH;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // ROM strobe, table select and address for the first cycle of each read state.
    always_comb begin
        rd_enter_s = 1'b0;
        rom_sel_s  = 1'b0;
        rom_addr_s = '0;
        if (state_s != state_r) begin
            case (state_s)
                RD_D: begin
                    rd_enter_s = 1'b1;
                    rom_addr_s = frame_i(next_frame_s);
                end
                RD_OK: begin
                    rd_enter_s = 1'b1;
                    rom_sel_s  = 1'b1;
                    rom_addr_s = frame_k(next_frame_s) - IW'(1);
                end
                RD_OL: begin
                    rd_enter_s = 1'b1;
                    rom_sel_s  = 1'b1;
                    rom_addr_s = frame_l(next_frame_s);
                end
                default: begin
                    rd_enter_s = 1'b0;
                    rom_sel_s  = 1'b0;
                    rom_addr_s = '0;
                end
            endcase
        end else begin
            rd_enter_s = 1'b0;
            rom_sel_s  = 1'b0;
            rom_addr_s = '0;
        end
    end

    // State register and per-state cycle counter for the ROM read states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            if (state_s != state_r)                      cnt_r <= '0;
            else if (state_r inside {RD_D, RD_OK, RD_OL}) cnt_r <= cnt_r + CW'(1);
            else                                          cnt_r <= '0;
        end
    end

    // Stack pointer, current frame, fetched data, push bookkeeping and overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp_r          <= '0;
            cur_frame_r   <= '0;
            overflow_r    <= 1'b0;
            push_frames_r <= '0;
            push_idx_r    <= 2'd0;
            ex_d_r        <= '0;
            ex_occ_k_r    <= '0;
            ex_occ_l_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        sp_r       <= SPW'(1);
                        overflow_r <= 1'b0;
                    end
                end
                POP: begin
                    cur_frame_r <= stack_r[top_idx_s];
                    sp_r        <= sp_r - SPW'(1);
                end
                RD_D: begin
                    if (rd_last_s) begin
                        ex_d_r <= bus.rom_data;
                        if (k_zero_s) ex_occ_k_r <= '0;
                    end
                end
                RD_OK: if (rd_last_s) ex_occ_k_r <= bus.rom_data;
                RD_OL: if (rd_last_s) ex_occ_l_r <= bus.rom_data;
                EXEC: begin
                    if (accept_s) begin
                        push_frames_r <= bus.ex_push_frames;
                        push_idx_r    <= 2'(push_cnt_sat_s - 3'd1);
                    end
                end
                PUSH: begin
                    if (stack_full_s) overflow_r <= 1'b1;
                    else              sp_r       <= sp_r + SPW'(1);
                    push_idx_r <= push_idx_r - 2'd1;
                end
                default: ;
            endcase
        end
    end

    // Frame storage; contents are only meaningful below sp_r, so it needs no reset.
    always_ff @(posedge clk) begin
        if (state_r == IDLE && bus.start)
            stack_r[AW'(0)] <= bus.root_frame;
        else if (state_r == PUSH && !stack_full_s)
            stack_r[AW'(sp_r)] <= push_frame_s;
    end

    // Registered status, handshake and ROM-interface outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            ex_valid_r <= 1'b0;
            rom_ce_r   <= 1'b0;
            rom_sel_r  <= 1'b0;
            rom_addr_r <= '0;
        end else begin
            busy_r     <= (state_s != IDLE) && (state_s != DONE);
            done_r     <= (state_s == DONE);
            ex_valid_r <= (state_s == EXEC);
            rom_ce_r   <= rd_enter_s;
            rom_sel_r  <= rom_sel_s;
            rom_addr_r <= rom_addr_s;
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.overflow = overflow_r;
    assign bus.rom_ce   = rom_ce_r;
    assign bus.rom_sel  = rom_sel_r;
    assign bus.rom_addr = rom_addr_r;
    assign bus.ex_valid = ex_valid_r;
    assign bus.ex_frame = cur_frame_r;
    assign bus.ex_d     = ex_d_r;
    assign bus.ex_occ_k = ex_occ_k_r;
    assign bus.ex_occ_l = ex_occ_l_r;
endmodule

// File: tb/tb_recur_sched_ctrl.sv
// Bench for recur_sched_ctrl (IW=8, DW=32, DEPTH=4, ROM_LAT=2): directed timing cases plus
// randomized traversals compared against a queue-based frame stack and a lookup-function ROM.
module tb_recur_sched_ctrl;
    localparam int IW = 8, DW = 32, DEPTH = 4, ROM_LAT = 2, FW = 4 * IW;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    recur_sched_ctrl_if #(.IW(IW), .DW(DW)) bus ();

    recur_sched_ctrl #(.IW(IW), .DW(DW), .DEPTH(DEPTH), .ROM_LAT(ROM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] rom_fn(input logic sel, input logic [IW-1:0] a);
        return {sel, 7'h15, a, ~a, a ^ 8'h5A};
    endfunction

    function automatic logic [FW-1:0] mk(input int i, input int z, input int k, input int l);
        return {8'(i), 8'(z), 8'(k), 8'(l)};
    endfunction

    function automatic logic [FW-1:0] rand_frame();
        int k;
        k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
        return mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), k,
                  int'($urandom_range(0, 255)));
    endfunction

    function automatic logic [DW-1:0] exp_occ_k(input logic [FW-1:0] f);
        logic [IW-1:0] k;
        k = f[2*IW-1 -: IW];
        if (k == 8'd0) return 32'd0;
        return rom_fn(1'b1, k - 8'd1);
    endfunction

    // ROM with a two-cycle read pipeline; unstrobed cycles return a poison word.
    logic [DW-1:0] rom_p0, rom_p1;
    always @(posedge clk) begin
        rom_p0 <= bus.rom_ce ? rom_fn(bus.rom_sel, bus.rom_addr) : 32'hDEAD_BEEF;
        rom_p1 <= rom_p0;
    end
    assign bus.rom_data = rom_p1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ex(input string tag, input logic [FW-1:0] f);
        chk({tag, ".frame"}, bus.ex_frame, f);
        chk({tag, ".d"},     bus.ex_d,     rom_fn(1'b0, f[4*IW-1 -: IW]));
        chk({tag, ".occk"},  bus.ex_occ_k, exp_occ_k(f));
        chk({tag, ".occl"},  bus.ex_occ_l, rom_fn(1'b1, f[IW-1:0]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".busy"},  bus.busy,     0);
        chk({tag, ".done"},  bus.done,     0);
        chk({tag, ".ovf"},   bus.overflow, 0);
        chk({tag, ".rom"},   {bus.rom_ce, bus.rom_sel, bus.rom_addr}, 0);
        chk({tag, ".exv"},   bus.ex_valid, 0);
        chk({tag, ".exf"},   bus.ex_frame, 0);
        chk({tag, ".exd"},   {bus.ex_d, bus.ex_occ_k}, 0);
        chk({tag, ".exol"},  bus.ex_occ_l, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_valid(input string tag, output int cyc);
        cyc = 0;
        while (!bus.ex_valid && cyc < 60) begin
            step();
            cyc++;
        end
        if (!bus.ex_valid) chk({tag, ".timeout"}, 0, 1);
    endtask

    // Push plans consumed one per accept before random or empty pushes take over.
    int              plan_cnt_q  [$];
    logic [4*FW-1:0] plan_kids_q [$];

    task automatic traverse(input string tag, input logic [FW-1:0] root, input bit rnd,
                            input int budget);
        logic [FW-1:0]   stk [$];
        logic [FW-1:0]   exp_f;
        logic [4*FW-1:0] kids;
        bit ovf, got, fin;
        int cnt, n_eff, seen, stall, strobes;
        stk = {root};
        ovf = 1'b0;
        seen = 0;
        fin = 1'b0;
        bus.root_frame = root;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        while (!fin) begin
            got = 1'b0;
            strobes = 0;
            for (int c = 0; c < 60 && !got; c++) begin
                if (bus.ex_valid) got = 1'b1;
                else begin
                    if (bus.rom_ce) strobes++;
                    else chk({tag, ".rom_idle"}, {bus.rom_sel, bus.rom_addr}, 0);
                    step();
                end
            end
            if (!got) begin
                chk({tag, ".valid_timeout"}, 0, 1);
                do_reset();
                return;
            end
            exp_f = stk.pop_back();
            seen++;
            chk_ex(tag, exp_f);
            chk({tag, ".strobes"}, strobes, (exp_f[2*IW-1 -: IW] == 8'd0) ? 2 : 3);
            chk({tag, ".ovf_live"}, bus.overflow, ovf);
            chk({tag, ".busy"}, bus.busy, 1);
            stall = rnd ? int'($urandom_range(0, 2)) : 0;
            bus.ex_ready = 1'b0;
            for (int s = 0; s < stall; s++) begin
                step();
                chk({tag, ".stall_valid"}, bus.ex_valid, 1);
            end
            if (stall > 0) chk_ex({tag, ".stalled"}, exp_f);
            for (int j = 0; j < 4; j++) kids[j*FW +: FW] = rand_frame();
            if (plan_cnt_q.size() > 0) begin
                cnt  = plan_cnt_q.pop_front();
                kids = plan_kids_q.pop_front();
            end else if (rnd && seen < budget) begin
                cnt = int'($urandom_range(0, 7));
            end else begin
                cnt = 0;
            end
            bus.ex_push_cnt    = 3'(cnt);
            bus.ex_push_frames = kids;
            bus.ex_ready       = 1'b1;
            step();
            bus.ex_ready    = 1'b0;
            bus.ex_push_cnt = 3'd0;
            n_eff = (cnt > 4) ? 4 : cnt;
            for (int j = n_eff - 1; j >= 0; j--) begin
                if (stk.size() == DEPTH) ovf = 1'b1;
                else stk.push_back(kids[j*FW +: FW]);
            end
            if (stk.size() == 0) fin = 1'b1;
        end
        chk({tag, ".done"}, bus.done, 1);
        chk({tag, ".done_busy"}, bus.busy, 0);
        chk({tag, ".done_ovf"}, bus.overflow, ovf);
        step();
        chk({tag, ".done_pulse"}, bus.done, 0);
        step();
        chk({tag, ".idle_ovf"}, bus.overflow, ovf);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] fa, fb, fc;
        logic [IW-1:0] occ_addr;
        bit occ_seen;
        int cyc;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.root_frame = '0;
        bus.ex_ready = 1'b0;
        bus.ex_push_cnt = 3'd0;
        bus.ex_push_frames = '0;
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();

        // Root {3,1,0,10}: exact cycle-by-cycle schedule, start driven in cycle 0.
        bus.root_frame = mk(3, 1, 0, 10);
        bus.ex_ready = 1'b1;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("c1.busy", bus.busy, 1);
        chk("c1.rom_ce", bus.rom_ce, 0);
        step();
        chk("c2.rd_d", {bus.rom_ce, bus.rom_sel, bus.rom_addr}, {2'b10, 8'd3});
        step();
        chk("c3.rom", {bus.rom_ce, bus.rom_sel, bus.rom_addr}, 0);
        step();
        chk("c4.rom", {bus.rom_ce, bus.rom_sel, bus.rom_addr}, 0);
        step();
        chk("c5.rd_ol", {bus.rom_ce, bus.rom_sel, bus.rom_addr}, {2'b11, 8'd10});
        step();
        step();
        chk("c7.exv", bus.ex_valid, 0);
        step();
        chk("c8.exv", bus.ex_valid, 1);
        chk_ex("c8", mk(3, 1, 0, 10));
        step();
        chk("c9.done", {bus.done, bus.busy, bus.ex_valid}, 3'b100);
        step();
        chk("c10.done", bus.done, 0);
        bus.ex_ready = 1'b0;

        // Same root with k=5: Occ(k-1) read at address 4, ex_valid in cycle 11.
        bus.root_frame = mk(3, 1, 5, 10);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 1;
        occ_seen = 1'b0;
        occ_addr = 8'd0;
        while (!bus.ex_valid && cyc < 40) begin
            if (bus.rom_ce && bus.rom_sel && !occ_seen) begin
                occ_seen = 1'b1;
                occ_addr = bus.rom_addr;
            end
            step();
            cyc++;
        end
        chk("k5.valid_cycle", cyc, 11);
        chk("k5.occ_addr", {occ_seen, occ_addr}, {1'b1, 8'd4});
        chk_ex("k5", mk(3, 1, 5, 10));
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        chk("k5.done", bus.done, 1);
        step();

        // Three children A,B,C in slots 0..2 are processed in that order.
        fa = mk(10, 0, 0, 1);
        fb = mk(20, 0, 2, 2);
        fc = mk(30, 0, 0, 3);
        plan_cnt_q  = {3};
        plan_kids_q = {{mk(0, 0, 0, 0), fc, fb, fa}};
        traverse("push3", mk(1, 0, 1, 0), 1'b0, 0);

        // Root pushes 3, first child pushes 4 onto a depth-4 stack: pushes are dropped.
        plan_cnt_q  = {3, 4};
        plan_kids_q = {{mk(0, 0, 0, 0), fc, fb, fa},
                       {mk(44, 0, 0, 4), mk(43, 0, 3, 3), mk(42, 0, 0, 2), mk(41, 0, 1, 1)}};
        traverse("ovf", mk(2, 0, 0, 5), 1'b0, 0);

        // Long stall in EXEC with a start pulse inside the window.
        bus.root_frame = mk(7, 2, 3, 9);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid("stall", cyc);
        chk("stall.ovf_cleared", bus.overflow, 0);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) begin
                bus.root_frame = mk(1, 1, 1, 1);
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            step();
            chk("stall.valid", bus.ex_valid, 1);
            chk_ex("stall", mk(7, 2, 3, 9));
        end
        bus.start = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        bus.ex_ready = 1'b0;
        chk("stall.done", bus.done, 1);
        repeat (3) step();
        chk("stall.no_restart", {bus.busy, bus.done}, 0);

        // Reset asserted while in RD_OL.
        bus.root_frame = mk(2, 0, 0, 6);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (!(bus.rom_ce && bus.rom_sel && bus.rom_addr == 8'd6) && cyc < 40) begin
            step();
            cyc++;
        end
        chk("rst.found_rd_ol", cyc < 40, 1);
        step();
        rst = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rst.after", {bus.busy, bus.done}, 0);
        end

        // Randomized traversals with random child counts (including >4) and stalls.
        for (int t = 0; t < 10; t++) traverse("rnd", rand_frame(), 1'b1, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
